// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: unsigned 8x8 -> 16-bit pipelined Wallace-tree multiplier.
// Three register stages: operand capture, carry-save rows, final sum.
// Latency: operands sampled at edge k appear on out after edge k+2.
// Optional macro WALLACE_VALID_EN adds in_valid/out_valid that travel
// alongside the data through a 3-stage valid pipeline.
module wallace_mult_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
`ifdef WALLACE_VALID_EN
  input  logic        in_valid,
  output logic        out_valid,
`endif
  output logic [15:0] out
);

  // Full adder (3:2): returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // Half adder (2:2): returns {carry, sum}.
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // One row of full adders across all 16 columns: returns {carry_row, sum_row}.
  // The carry out of column 15 has weight 2^16 and is dropped; the product
  // never reaches that weight, so the tree stays exact modulo 2^16.
  function automatic logic [31:0] csa3(input logic [15:0] x,
                                       input logic [15:0] y,
                                       input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    logic [1:0]  t;
    s    = '0;
    c    = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      t      = fa(x[i], y[i], z[i]);
      s[i]   = t[0];
      c[i+1] = t[1];
    end
    s[15] = x[15] ^ y[15] ^ z[15];
    return {c, s};
  endfunction

  // One row of half adders across all 16 columns: returns {carry_row, sum_row}.
  function automatic logic [31:0] csa2(input logic [15:0] x,
                                       input logic [15:0] y);
    logic [15:0] s;
    logic [15:0] c;
    logic [1:0]  t;
    s    = '0;
    c    = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      t      = ha(x[i], y[i]);
      s[i]   = t[0];
      c[i+1] = t[1];
    end
    s[15] = x[15] ^ y[15];
    return {c, s};
  endfunction

  // Stage 0 registers
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  // Stage 1 registers
  logic [15:0] r_sum_row;
  logic [15:0] r_carry_row;
  // Stage 2 register
  logic [15:0] r_out;

  // Partial products, each row pre-shifted to its weight
  logic [15:0] w_pp [8];

  // Layer 1: 8 rows -> 6 rows
  logic [15:0] w_l1_s0, w_l1_c0, w_l1_s1, w_l1_c1, w_l1_s2, w_l1_c2;
  // Layer 2: 6 rows -> 4 rows
  logic [15:0] w_l2_s0, w_l2_c0, w_l2_s1, w_l2_c1;
  // Layer 3: 4 rows -> 3 rows
  logic [15:0] w_l3_s0, w_l3_c0;
  // Layer 4: 3 rows -> 2 rows
  logic [15:0] w_l4_s, w_l4_c;
  // Final carry-propagate sum
  logic [15:0] w_final;

  // Partial-product generation: row i is (a_r & b_r[i]) weighted by 2^i
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      w_pp[i]        = '0;
      w_pp[i][i +: 8] = r_a & {8{r_b[i]}};
    end
  end

  assign {w_l1_c0, w_l1_s0} = csa3(w_pp[0], w_pp[1], w_pp[2]);
  assign {w_l1_c1, w_l1_s1} = csa3(w_pp[3], w_pp[4], w_pp[5]);
  assign {w_l1_c2, w_l1_s2} = csa2(w_pp[6], w_pp[7]);

  assign {w_l2_c0, w_l2_s0} = csa3(w_l1_s0, w_l1_c0, w_l1_s1);
  assign {w_l2_c1, w_l2_s1} = csa3(w_l1_c1, w_l1_s2, w_l1_c2);

  // Fourth row (w_l2_c1) passes through this layer untouched
  assign {w_l3_c0, w_l3_s0} = csa3(w_l2_s0, w_l2_c0, w_l2_s1);

  assign {w_l4_c, w_l4_s}   = csa3(w_l3_s0, w_l3_c0, w_l2_c1);

  // Carry out of bit 15 is discarded; it is always 0 for 8-bit operands
  assign w_final = r_sum_row + r_carry_row;

  // Stage 0: capture operands
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Stage 1: register the two carry-save rows
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum_row   <= '0;
      r_carry_row <= '0;
    end else begin
      r_sum_row   <= w_l4_s;
      r_carry_row <= w_l4_c;
    end
  end

  // Stage 2: register the final product
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_final;
    end
  end

  assign out = r_out;

`ifdef WALLACE_VALID_EN
  logic [2:0] r_vld;

  // Valid pipeline: shifts in lock-step with the data stages
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[1:0], in_valid};
    end
  end

  assign out_valid = r_vld[2];
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench for wallace_mult_pipe (directed + random stimulus).
module tb_wallace_mult_pipe;

  logic        clk = 1'b0;
  logic        tb_reset;
  logic [7:0]  tb_a;
  logic [7:0]  tb_b;
  logic        tb_in_valid;
  logic        tb_out_valid;
  logic [15:0] tb_out;

  int total = 0;
  int bad   = 0;

  // Reference model: each entry is what out must show N edges later
  int exp_q [$];
  int vld_q [$];

  always #5 clk = ~clk;

  wallace_mult_pipe dut (
    .clk       (clk),
    .reset     (tb_reset),
    .a         (tb_a),
    .b         (tb_b),
`ifdef WALLACE_VALID_EN
    .in_valid  (tb_in_valid),
    .out_valid (tb_out_valid),
`endif
    .out       (tb_out)
  );

`ifndef WALLACE_VALID_EN
  assign tb_out_valid = 1'b0;
`endif

  // Drive one cycle of inputs, advance one edge, update model, check out.
  task automatic step(input logic rst, input logic [7:0] ia, input logic [7:0] ib,
                      input logic iv, input string tag);
    int exp;
    int expv;
    tb_reset    = rst;
    tb_a        = ia;
    tb_b        = ib;
    tb_in_valid = iv;
    @(posedge clk);
    if (rst) begin
      exp_q = '{0, 0, 0};
      vld_q = '{0, 0, 0};
    end else begin
      exp_q.push_back(int'(ia) * int'(ib));
      exp_q.pop_front();
      vld_q.push_back(iv ? 1 : 0);
      vld_q.pop_front();
    end
    exp  = exp_q[0];
    expv = vld_q[0];
    #1;
    total++;
    assert (tb_out === 16'(exp)) else begin
      bad++;
      $error("FAIL %s out=%0d expected=%0d", tag, tb_out, exp);
    end
`ifdef WALLACE_VALID_EN
    total++;
    assert (tb_out_valid === 1'(expv)) else begin
      bad++;
      $error("FAIL %s_valid out_valid=%0d expected=%0d", tag, tb_out_valid, expv);
    end
`else
    if (expv > 1) $display("unexpected model state");
`endif
  endtask

  initial begin
    logic [7:0] sa [4];
    logic [7:0] sb [4];
    logic [7:0] ca [7];
    logic [7:0] cb [7];
    sa = '{8'd7, 8'd119, 8'd103, 8'd247};
    sb = '{8'd63, 8'd106, 8'd63, 8'd188};
    ca = '{8'd0, 8'd255, 8'd1, 8'd255, 8'd247, 8'd15, 8'd15};
    cb = '{8'd0, 8'd255, 8'd255, 8'd1, 8'd129, 8'd11, 8'd31};

    tb_reset = 1'b1; tb_a = '0; tb_b = '0; tb_in_valid = 1'b0;
    @(negedge clk);

    // Reset held two edges with a=3, b=55, then released
    step(1'b1, 8'd3, 8'd55, 1'b1, "reset0");
    step(1'b1, 8'd3, 8'd55, 1'b1, "reset1");
    step(1'b0, 8'd3, 8'd55, 1'b1, "rel0");
    step(1'b0, 8'd3, 8'd55, 1'b1, "rel1");
    step(1'b0, 8'd3, 8'd55, 1'b1, "rel2");
    total++;
    assert (tb_out === 16'd165) else begin
      bad++;
      $error("FAIL rel_165 out=%0d expected=165", tb_out);
    end

    // Streaming, one pair per cycle
    for (int i = 0; i < 4; i++) step(1'b0, sa[i], sb[i], 1'b1, "stream");
    step(1'b0, 8'd0, 8'd0, 1'b1, "stream_flush");
    step(1'b0, 8'd0, 8'd0, 1'b1, "stream_flush");

    // Corner operands
    for (int i = 0; i < 7; i++) step(1'b0, ca[i], cb[i], 1'b1, "corner");
    step(1'b0, 8'd0, 8'd0, 1'b1, "corner_flush");
    step(1'b0, 8'd0, 8'd0, 1'b1, "corner_flush");

    // Hold stable operands; also sample mid-cycle to catch glitches
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'd15, 8'd3, 1'b1, "hold");
      if (i >= 2) begin
        @(negedge clk);
        total++;
        assert (tb_out === 16'd45) else begin
          bad++;
          $error("FAIL hold_mid out=%0d expected=45", tb_out);
        end
      end
    end

    // Reset mid-stream: 12614 must never appear
    step(1'b0, 8'd119, 8'd106, 1'b1, "mid_op");
    step(1'b1, 8'd5, 8'd5, 1'b1, "mid_rst");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd9, 8'd7, 1'b1, "mid_resume");
      total++;
      assert (tb_out !== 16'd12614) else begin
        bad++;
        $error("FAIL mid_leak out=%0d expected=not_12614", tb_out);
      end
    end

    // Valid pattern 1,0,1
    step(1'b0, 8'd3, 8'd5, 1'b1, "vpat");
    step(1'b0, 8'd9, 8'd9, 1'b0, "vpat");
    step(1'b0, 8'd4, 8'd4, 1'b1, "vpat");
    step(1'b0, 8'd0, 8'd0, 1'b0, "vpat_flush");
    step(1'b0, 8'd0, 8'd0, 1'b0, "vpat_flush");

    // Random stimulus with occasional reset and random valid
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 24) == 0), 8'($urandom), 8'($urandom),
           1'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
